// File: rtl/benes_cfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | benes_cfg_sequencer: shadow-loads Benes switch settings and commits them  |
// | atomically once the switch pipeline has drained.       Rev 1.0            |
// +--------------------------------------------------------------------------+
module benes_cfg_sequencer #(
  parameter int SIZE       = 32,
  parameter int SWITCH_NUM = SIZE / 2,
  parameter int STAGE_NUM  = 2 * $clog2(SIZE) - 1,
  parameter int LATENCY    = STAGE_NUM - 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [SWITCH_NUM-1:0]           cfg_module_sel,
  input  logic [SWITCH_NUM-1:0]           cfg_slot_sel,
  input  logic                            cfg_last,
  input  logic                            xfer_valid,
  output logic                            issue_ok,
  output logic [STAGE_NUM*SWITCH_NUM-1:0] o_module_select,
  output logic [STAGE_NUM*SWITCH_NUM-1:0] o_slot_select,
  output logic                            o_commit,
  output logic [7:0]                      o_epoch,
  output logic                            o_busy,
  output logic                            o_err_len,
  output logic                            o_err_issue
);

  localparam int WPTR_W  = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
  localparam int DRAIN_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int SEL_W   = STAGE_NUM * SWITCH_NUM;

  localparam logic [WPTR_W-1:0]  LAST_PTR  = WPTR_W'(STAGE_NUM - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t              state;
  logic [WPTR_W-1:0]   wptr;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [SEL_W-1:0]    shadow_mod;
  logic [SEL_W-1:0]    shadow_slot;

  logic beat_accept;
  logic issue_accept;
  logic at_last;

  assign cfg_ready    = (state != PEND);
  assign issue_ok     = (state != PEND);
  assign o_busy       = (state != IDLE);
  assign beat_accept  = cfg_valid & cfg_ready;
  assign issue_accept = xfer_valid & issue_ok;
  assign at_last      = (wptr == LAST_PTR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      wptr            <= '0;
      drain_cnt       <= '0;
      shadow_mod      <= '0;
      shadow_slot     <= '0;
      o_module_select <= '0;
      o_slot_select   <= '0;
      o_commit        <= 1'b0;
      o_epoch         <= 8'd0;
      o_err_len       <= 1'b0;
      o_err_issue     <= 1'b0;
    end else begin
      o_commit <= 1'b0;

      if (xfer_valid && !issue_ok) begin
        o_err_issue <= 1'b1;
      end

      // Any accepted issue restarts the drain window; a rejected one never does.
      if (issue_accept) begin
        drain_cnt <= DRAIN_MAX;
      end else if (drain_cnt != '0) begin
        drain_cnt <= drain_cnt - 1'b1;
      end

      case (state)
        IDLE, LOAD: begin
          if (beat_accept) begin
            shadow_mod[int'(wptr)*SWITCH_NUM +: SWITCH_NUM]  <= cfg_module_sel;
            shadow_slot[int'(wptr)*SWITCH_NUM +: SWITCH_NUM] <= cfg_slot_sel;
            if (cfg_last && at_last) begin
              state <= PEND;
              wptr  <= '0;
            end else if (cfg_last || at_last) begin
              // Misplaced last: drop the partial load, active bank untouched.
              o_err_len <= 1'b1;
              wptr      <= '0;
              state     <= IDLE;
            end else begin
              wptr  <= wptr + 1'b1;
              state <= LOAD;
            end
          end
        end
        PEND: begin
          if (drain_cnt == '0) begin
            o_module_select <= shadow_mod;
            o_slot_select   <= shadow_slot;
            o_epoch         <= o_epoch + 8'd1;
            o_commit        <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
